// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA raster timing generator:
//   - default 640x480@72 timing values (pixel clocks / lines)
//   - sync polarity constants
//   - the control-bundle type carried through the latency-matching delay line
//   - cnt_width(): counter width needed to count 0 .. total-1
// -----------------------------------------------------------------------------
package vga_pkg;

    // Default horizontal timing, in pixel clocks
    localparam int unsigned DEF_H_ACTIVE = 32'd640;
    localparam int unsigned DEF_H_FP     = 32'd24;
    localparam int unsigned DEF_H_SYNC   = 32'd40;
    localparam int unsigned DEF_H_BP     = 32'd128;

    // Default vertical timing, in lines
    localparam int unsigned DEF_V_ACTIVE = 32'd480;
    localparam int unsigned DEF_V_FP     = 32'd9;
    localparam int unsigned DEF_V_SYNC   = 32'd3;
    localparam int unsigned DEF_V_BP     = 32'd28;

    // Sync polarity: the level the pin takes while the pulse is asserted
    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    // Deepest pixel-generator latency the delay line supports
    localparam int unsigned MAX_PIX_LAT = 32'd4;

    // Raw (active-high, polarity-free) control bits for one pixel.
    // All-zero means blank with both syncs inactive, so clearing the
    // delay line to zero gives the idle state.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
    } vga_ctrl_t;

    // Width of a counter that must hold 0 .. total-1 (never narrower than 1)
    function automatic int unsigned cnt_width(input int unsigned total);
        if (total > 32'd1) begin
            return $clog2(total);
        end else begin
            return 32'd1;
        end
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// -----------------------------------------------------------------------------
// vga_delay_line
// WIDTH x DEPTH shift register. Every stage advances only when i_en is high.
// Asynchronous active-low clear sets every stage to zero. DEPTH = 0 is a
// combinational pass-through (o_q = i_d).
// Ports:
//   i_clk    clock
//   i_clr_n  asynchronous active-low clear
//   i_en     shift enable
//   i_d      data into the first stage
//   o_q      data out of the last stage
// -----------------------------------------------------------------------------
module vga_delay_line #(
    parameter int unsigned WIDTH = 32'd1,
    parameter int unsigned DEPTH = 32'd1
) (
    input  logic             i_clk,
    input  logic             i_clr_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 32'd0) begin : g_pass
            // No storage: clock, clear and enable are intentionally ignored
            logic w_unused;
            assign w_unused = i_clk ^ i_clr_n ^ i_en;
            assign o_q      = i_d;
        end else begin : g_shift
            logic [DEPTH-1:0][WIDTH-1:0] r_stage;

            // Shift register: stage 0 takes the input, stage i takes stage i-1
            always_ff @(posedge i_clk or negedge i_clr_n) begin
                if (!i_clr_n) begin
                    r_stage <= '{default: {WIDTH{1'b0}}};
                end else if (i_en) begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < int'(DEPTH); i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster timing generator. Counters x/y scan the raster and
// drive an external pixel generator that answers PIX_LAT enabled clocks later.
// The undelayed sync/display-enable go through a PIX_LAT-deep delay line so
// they line up with the returned colour, then hsync/vsync/de/rgb are
// registered onto the pins.
//
// Optional feature macro VGA_TIMING_BLANK_EN:
//   defined   - rgb loads zero whenever the delayed display-enable is low
//   undefined - rgb loads rgb_in unconditionally (generator does the blanking)
//
// Ports:
//   clk          pixel clock
//   reset        asynchronous active-low reset
//   en           pixel-clock enable; all state holds while low
//   x, y         current horizontal / vertical count
//   active       combinational: x < H_ACTIVE and y < V_ACTIVE (undelayed)
//   line_start   x == 0 and en
//   frame_start  x == 0, y == 0 and en
//   rgb_in       colour for the pixel presented PIX_LAT enabled clocks earlier
//   hsync, vsync registered syncs with HSYNC_POL / VSYNC_POL active level
//   de           registered display enable
//   rgb          registered colour
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP,
    parameter logic        HSYNC_POL = SYNC_ACTIVE_LOW,
    parameter logic        VSYNC_POL = SYNC_ACTIVE_LOW,
    parameter int unsigned RGB_W     = 32'd3,
    parameter int unsigned PIX_LAT   = 32'd1,
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned X_W      = cnt_width(H_TOTAL),
    localparam int unsigned Y_W      = cnt_width(V_TOTAL)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [X_W-1:0]   x,
    output logic [Y_W-1:0]   y,
    output logic             active,
    output logic             line_start,
    output logic             frame_start,
    input  logic [RGB_W-1:0] rgb_in,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [RGB_W-1:0] rgb
);

    // Region boundaries as counter-width constants
    localparam logic [X_W-1:0] X_LAST     = X_W'(H_TOTAL - 32'd1);
    localparam logic [X_W-1:0] X_ACT_END  = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] X_SYNC_BEG = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] X_SYNC_END = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0] Y_LAST     = Y_W'(V_TOTAL - 32'd1);
    localparam logic [Y_W-1:0] Y_ACT_END  = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] Y_SYNC_BEG = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] Y_SYNC_END = Y_W'(V_ACTIVE + V_FP + V_SYNC);

    // Reject unusable configurations at elaboration
    generate
        if (H_ACTIVE == 32'd0 || H_FP == 32'd0 || H_SYNC == 32'd0 || H_BP == 32'd0 ||
            V_ACTIVE == 32'd0 || V_FP == 32'd0 || V_SYNC == 32'd0 || V_BP == 32'd0) begin : g_bad_timing
            $error("vga_timing_gen: every timing parameter must be non-zero");
        end
        if (PIX_LAT > MAX_PIX_LAT) begin : g_bad_latency
            $error("vga_timing_gen: PIX_LAT must be in 0..4");
        end
    endgenerate

    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic             w_x_last;
    logic             w_y_last;
    vga_ctrl_t        w_ctrl_now;
    vga_ctrl_t        w_ctrl_dly;
    logic [RGB_W-1:0] w_rgb_next;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_de;
    logic [RGB_W-1:0] r_rgb;

    assign w_x_last = (r_x == X_LAST);
    assign w_y_last = (r_y == Y_LAST);

    // Raster counters: x every enabled clock, y on each x wrap, no idle cycles at wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x <= {X_W{1'b0}};
            r_y <= {Y_W{1'b0}};
        end else if (en) begin
            if (w_x_last) begin
                r_x <= {X_W{1'b0}};
                if (w_y_last) begin
                    r_y <= {Y_W{1'b0}};
                end else begin
                    r_y <= r_y + 1'b1;
                end
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    // Region decode for the pixel currently on x/y (raw, active-high)
    always_comb begin
        w_ctrl_now       = '{hsync: 1'b0, vsync: 1'b0, de: 1'b0};
        w_ctrl_now.hsync = (r_x >= X_SYNC_BEG) && (r_x < X_SYNC_END);
        w_ctrl_now.vsync = (r_y >= Y_SYNC_BEG) && (r_y < Y_SYNC_END);
        w_ctrl_now.de    = (r_x < X_ACT_END) && (r_y < Y_ACT_END);
    end

    // Match the pixel generator's latency so controls meet their colour
    vga_delay_line #(
        .WIDTH ($bits(vga_ctrl_t)),
        .DEPTH (PIX_LAT)
    ) u_ctrl_dly (
        .i_clk   (clk),
        .i_clr_n (reset),
        .i_en    (en),
        .i_d     (w_ctrl_now),
        .o_q     (w_ctrl_dly)
    );

    // Colour loaded into the output register
    always_comb begin
        w_rgb_next = {RGB_W{1'b0}};
`ifdef VGA_TIMING_BLANK_EN
        if (w_ctrl_dly.de) begin
            w_rgb_next = rgb_in;
        end else begin
            w_rgb_next = {RGB_W{1'b0}};
        end
`else
        w_rgb_next = rgb_in;
`endif
    end

    // Pin registers: apply sync polarity and capture colour on enabled clocks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hsync <= ~HSYNC_POL;
            r_vsync <= ~VSYNC_POL;
            r_de    <= 1'b0;
            r_rgb   <= {RGB_W{1'b0}};
        end else if (en) begin
            r_hsync <= w_ctrl_dly.hsync ? HSYNC_POL : ~HSYNC_POL;
            r_vsync <= w_ctrl_dly.vsync ? VSYNC_POL : ~VSYNC_POL;
            r_de    <= w_ctrl_dly.de;
            r_rgb   <= w_rgb_next;
        end
    end

    assign x           = r_x;
    assign y           = r_y;
    assign active      = w_ctrl_now.de;
    assign line_start  = en & (r_x == {X_W{1'b0}});
    assign frame_start = en & (r_x == {X_W{1'b0}}) & (r_y == {Y_W{1'b0}});
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign rgb         = r_rgb;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Small raster (28 x 17) with PIX_LAT = 2. The reference model only counts
// enabled clocks since reset (n); every expected output is derived from n by
// plain arithmetic on the raster rules. The pixel generator is played by the
// bench: it supplies colour(pixel n - PIX_LAT), or random junk when en = 0.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int HA = 16, HFP = 3, HS = 4, HBP = 5;
    localparam int VA = 10, VFP = 2, VS = 3, VBP = 2;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int PL = 2;
    localparam int RW = 3;
    localparam int XW = $clog2(HT);
    localparam int YW = $clog2(VT);

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [RW-1:0] rgb_in;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          active, line_start, frame_start, hsync, vsync, de;
    logic [RW-1:0] rgb;

    int            errors = 0;
    int            checks = 0;
    int            n = 0;          // model: enabled clocks since reset
    logic [RW-1:0] salt = 3'd0;    // colour pattern = x ^ salt
    logic          white = 1'b0;   // colour pattern = constant 3'b111

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .RGB_W(RW), .PIX_LAT(PL)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .x(x), .y(y), .active(active),
        .line_start(line_start), .frame_start(frame_start), .rgb_in(rgb_in),
        .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: actual=%0d required=%0d (t=%0t n=%0d)", name, act, exp, $time, n);
        end
    endtask

    // colour the generator returns for linear pixel index p
    function automatic logic [RW-1:0] colour(input int p);
        if (white) return 3'b111;
        return RW'(p % HT) ^ salt;
    endfunction

    // model counter: follows reset and en exactly as the raster rules say
    always @(posedge clk) begin
        if (!reset) n <= 0;
        else if (en) n <= n + 1;
    end

    // per-cycle comparison of every output against the model
    always @(negedge clk) begin
        int ex, ey, p, xp, yp;
        logic e_hs, e_vs, e_de;
        logic [RW-1:0] e_rgb;
        if (!reset) begin
            ex = 0; ey = 0; p = -1;
        end else begin
            ex = n % HT; ey = (n / HT) % VT; p = n - 1 - PL;
        end
        if (p >= 0) begin
            xp = p % HT; yp = (p / HT) % VT;
            e_hs = (xp >= HA + HFP) && (xp < HA + HFP + HS);
            e_vs = (yp >= VA + VFP) && (yp < VA + VFP + VS);
            e_de = (xp < HA) && (yp < VA);
        end else begin
            e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0;
        end
        if (!reset || n == 0) e_rgb = 3'd0;
        else if (white) e_rgb = 3'b111;
        else if (p >= 0) e_rgb = colour(p);
        else e_rgb = 3'd0;
`ifdef VGA_TIMING_BLANK_EN
        if (!e_de) e_rgb = 3'd0;
`endif
        chk("x", 64'(x), 64'(ex));
        chk("y", 64'(y), 64'(ey));
        chk("active", 64'(active), 64'((ex < HA) && (ey < VA)));
        chk("line_start", 64'(line_start), 64'(en && ex == 0));
        chk("frame_start", 64'(frame_start), 64'(en && ex == 0 && ey == 0));
        chk("hsync", 64'(hsync), 64'(!e_hs));
        chk("vsync", 64'(vsync), 64'(!e_vs));
        chk("de", 64'(de), 64'(e_de));
        chk("rgb", 64'(rgb), 64'(e_rgb));
    end

    // one clock of stimulus; returns at the following negedge
    task automatic drive(input logic e, input logic r);
        @(posedge clk);
        #1;
        reset = r;
        en    = e;
        if (!e) rgb_in = RW'($urandom);
        else if (white) rgb_in = 3'b111;
        else if (n < PL) rgb_in = 3'd0;
        else rgb_in = colour(n - PL);
        @(negedge clk);
    endtask

    initial begin
        int t_ls, t_fs, n_fs, hs_falls, hs_low, vs_falls, vs_low, de_runs, de_len, overlap, k;
        logic hs_prev, vs_prev, de_prev;
        logic [RW-1:0] rgb_prev;
        reset = 1'b0; en = 1'b1; rgb_in = 3'd0;

        // reset held with en high
        repeat (10) drive(1'b1, 1'b0);

        // two full frames with en high, salt 0: hand-derived timing literals
        t_ls = 0; t_fs = 0; n_fs = 0; hs_falls = 0; hs_low = 0; vs_falls = 0; vs_low = 0;
        de_runs = 0; de_len = 0; overlap = 0;
        hs_prev = 1'b1; vs_prev = 1'b1; de_prev = 1'b0; rgb_prev = 3'd0;
        for (int c = 0; c < 2 * HT * VT; c++) begin
            drive(1'b1, 1'b1);
            if (line_start) t_ls = c;
            if (frame_start) begin
                if (n_fs > 0) chk("frame_period", 64'(c - t_fs), 64'd476);
                t_fs = c; n_fs++;
            end
            if (hs_prev && !hsync) begin
                hs_falls++; hs_low = 0;
                chk("hsync_fall_offset", 64'(c - t_ls), 64'd22);
            end
            if (!hsync) hs_low++;
            if (!hs_prev && hsync) chk("hsync_low_width", 64'(hs_low), 64'd4);
            if (vs_prev && !vsync) begin vs_falls++; vs_low = 0; end
            if (!vsync) vs_low++;
            if (!vs_prev && vsync) chk("vsync_low_width", 64'(vs_low), 64'd84);
            if (de && !de_prev) begin
                de_runs++; de_len = 0;
                chk("rgb_first_de", 64'(rgb), 64'd0);
            end
            if (de && de_prev) chk("rgb_step", 64'(rgb), 64'(3'(rgb_prev + 3'd1)));
            if (de) de_len++;
            if (!de && de_prev) chk("de_width", 64'(de_len), 64'd16);
            if (de && (!hsync || !vsync)) overlap++;
            hs_prev = hsync; vs_prev = vsync; de_prev = de; rgb_prev = rgb;
        end
        chk("frame_start_count", 64'(n_fs), 64'd2);
        chk("hsync_fall_count", 64'(hs_falls), 64'd34);
        chk("vsync_fall_count", 64'(vs_falls), 64'd2);
        chk("de_run_count", 64'(de_runs), 64'd20);
        chk("de_during_sync", 64'(overlap), 64'd0);

        // en toggling 1,0: frame period doubles
        drive(1'b1, 1'b0);
        salt = 3'd5;
        drive(1'b1, 1'b0);
        n_fs = 0; t_fs = 0;
        for (int c = 0; c < 960; c++) begin
            drive((c % 2) == 0, 1'b1);
            if (frame_start) begin
                if (n_fs > 0) chk("frame_period_en_half", 64'(c - t_fs), 64'd952);
                t_fs = c; n_fs++;
            end
        end
        chk("frame_start_count_en_half", 64'(n_fs), 64'd2);

        // random enable, random colour salt, occasional reset pulses
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                drive(1'b1, 1'b0);
                salt  = RW'($urandom);
                white = ($urandom_range(0, 3) == 0);
                k = $urandom_range(0, 2);
                repeat (k) drive(1'b1, 1'b0);
            end else begin
                drive($urandom_range(0, 3) != 0, 1'b1);
            end
        end

        // reset in the middle of a frame at x=9, y=5
        drive(1'b1, 1'b0);
        white = 1'b0; salt = 3'd2;
        for (int c = 0; c <= 5 * HT + 9; c++) drive(1'b1, 1'b1);
        chk("pre_reset_x", 64'(x), 64'd9);
        chk("pre_reset_y", 64'(y), 64'd5);
        drive(1'b1, 1'b0);
        chk("mid_reset_x", 64'(x), 64'd0);
        chk("mid_reset_hsync", 64'(hsync), 64'd1);
        chk("mid_reset_de", 64'(de), 64'd0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        chk("restart_frame_start", 64'(frame_start), 64'd1);
        for (int c = 0; c < HT * VT + 40; c++) drive(1'b1, 1'b1);

        // constant white input
        drive(1'b1, 1'b0);
        white = 1'b1;
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
`ifdef VGA_TIMING_BLANK_EN
        chk("white_blanked", 64'(rgb), 64'd0);
`else
        chk("white_after_first_en", 64'(rgb), 64'd7);
`endif
        for (int c = 0; c < 200; c++) drive($urandom_range(0, 1) == 1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
